// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Bundle between the decode side of the pipeline and the ID/EX register.
//
// master : drives the decoded instruction (ID_*) plus HOLD / FLUSH, and
//          observes the registered stage contents (ID_EX_*), STALL and
//          BubbleCount.
// slave  : the ID/EX register itself (id_ex_stage).
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
);

  // Pipeline control from the rest of the core
  logic                      HOLD;
  logic                      FLUSH;

  // Decoded instruction sitting in ID
  logic                      ID_Valid;
  logic [REG_ADDR_WIDTH-1:0] ID_RegisterRn1;
  logic [REG_ADDR_WIDTH-1:0] ID_RegisterRm2;
  logic                      ID_UsesRm;
  logic [REG_ADDR_WIDTH-1:0] ID_RegisterRd;
  logic [DATA_WIDTH-1:0]     ID_RegData1;
  logic [DATA_WIDTH-1:0]     ID_RegData2;
  logic [DATA_WIDTH-1:0]     ID_SignExtImm;
  logic [DATA_WIDTH-1:0]     ID_PC;
  logic                      ID_RegWrite;
  logic                      ID_MemRead;
  logic                      ID_MemWrite;
  logic                      ID_MemtoReg;
  logic                      ID_ALUSrc;
  logic                      ID_Branch;
  logic [1:0]                ID_ALUOp;

  // Registered stage contents presented to EX and the forwarding unit
  logic                      ID_EX_Valid;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_RegisterRn1;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_RegisterRm2;
  logic                      ID_EX_UsesRm;
  logic [REG_ADDR_WIDTH-1:0] ID_EX_RegisterRd;
  logic [DATA_WIDTH-1:0]     ID_EX_RegData1;
  logic [DATA_WIDTH-1:0]     ID_EX_RegData2;
  logic [DATA_WIDTH-1:0]     ID_EX_SignExtImm;
  logic [DATA_WIDTH-1:0]     ID_EX_PC;
  logic                      ID_EX_RegWrite;
  logic                      ID_EX_MemRead;
  logic                      ID_EX_MemWrite;
  logic                      ID_EX_MemtoReg;
  logic                      ID_EX_ALUSrc;
  logic                      ID_EX_Branch;
  logic [1:0]                ID_EX_ALUOp;

  // Hazard outputs
  logic                      STALL;
  logic [CNT_WIDTH-1:0]      BubbleCount;

  modport master (
    output HOLD, FLUSH, ID_Valid, ID_RegisterRn1, ID_RegisterRm2, ID_UsesRm,
           ID_RegisterRd, ID_RegData1, ID_RegData2, ID_SignExtImm, ID_PC,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
           ID_Branch, ID_ALUOp,
    input  ID_EX_Valid, ID_EX_RegisterRn1, ID_EX_RegisterRm2, ID_EX_UsesRm,
           ID_EX_RegisterRd, ID_EX_RegData1, ID_EX_RegData2, ID_EX_SignExtImm,
           ID_EX_PC, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
           ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Branch, ID_EX_ALUOp,
           STALL, BubbleCount
  );

  modport slave (
    input  HOLD, FLUSH, ID_Valid, ID_RegisterRn1, ID_RegisterRm2, ID_UsesRm,
           ID_RegisterRd, ID_RegData1, ID_RegData2, ID_SignExtImm, ID_PC,
           ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc,
           ID_Branch, ID_ALUOp,
    output ID_EX_Valid, ID_EX_RegisterRn1, ID_EX_RegisterRm2, ID_EX_UsesRm,
           ID_EX_RegisterRd, ID_EX_RegData1, ID_EX_RegData2, ID_EX_SignExtImm,
           ID_EX_PC, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite,
           ID_EX_MemtoReg, ID_EX_ALUSrc, ID_EX_Branch, ID_EX_ALUOp,
           STALL, BubbleCount
  );

endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register of the five-stage ARMv8 core, with load-use hazard
// detection, branch flush, global hold and a saturating bubble counter.
//
// Ports:
//   CLOCK    rising-edge clock
//   RESET_N  asynchronous active-low reset
//   bus      id_ex_stage_if.slave: ID_* decoded instruction, HOLD, FLUSH in;
//            ID_EX_* stage contents, STALL (combinational), BubbleCount out
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_WIDTH     = 64,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int ZERO_REG       = 31,
  parameter int CNT_WIDTH      = 16
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_WIDTH-1:0] rn1;
    logic [REG_ADDR_WIDTH-1:0] rm2;
    logic                      uses_rm;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0]     reg_data1;
    logic [DATA_WIDTH-1:0]     reg_data2;
    logic [DATA_WIDTH-1:0]     sign_ext_imm;
    logic [DATA_WIDTH-1:0]     pc;
    logic                      reg_write;
    logic                      mem_read;
    logic                      mem_write;
    logic                      mem_to_reg;
    logic                      alu_src;
    logic                      branch;
    logic [1:0]                alu_op;
  } stage_t;

  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_IDX = REG_ADDR_WIDTH'(ZERO_REG);
  localparam logic [CNT_WIDTH-1:0]      CNT_MAX  = '1;

  // A bubble carries XZR in every register field so the forwarding unit
  // never sees a match against it; this is also the reset image.
  function automatic stage_t bubble_value();
    stage_t b;
    b     = '0;
    b.rn1 = ZERO_IDX;
    b.rm2 = ZERO_IDX;
    b.rd  = ZERO_IDX;
    return b;
  endfunction

  localparam stage_t BUBBLE = bubble_value();

  stage_t                stage_q, stage_d, capture;
  logic [CNT_WIDTH-1:0]  bubble_cnt_q, bubble_cnt_d;
  logic                  load_use;

  // Snapshot of the instruction currently presented by ID.
  always_comb begin
    capture              = '0;
    capture.valid        = 1'b1;
    capture.rn1          = bus.ID_RegisterRn1;
    capture.rm2          = bus.ID_RegisterRm2;
    capture.uses_rm      = bus.ID_UsesRm;
    capture.rd           = bus.ID_RegisterRd;
    capture.reg_data1    = bus.ID_RegData1;
    capture.reg_data2    = bus.ID_RegData2;
    capture.sign_ext_imm = bus.ID_SignExtImm;
    capture.pc           = bus.ID_PC;
    capture.reg_write    = bus.ID_RegWrite;
    capture.mem_read     = bus.ID_MemRead;
    capture.mem_write    = bus.ID_MemWrite;
    capture.mem_to_reg   = bus.ID_MemtoReg;
    capture.alu_src      = bus.ID_ALUSrc;
    capture.branch       = bus.ID_Branch;
    capture.alu_op       = bus.ID_ALUOp;
  end

  // A load in EX whose destination feeds the instruction in ID. Loads to XZR
  // never create a dependency, and Rm only counts when it is actually read.
  assign load_use = stage_q.valid & stage_q.mem_read & bus.ID_Valid &
                    (stage_q.rd != ZERO_IDX) &
                    ((stage_q.rd == bus.ID_RegisterRn1) |
                     (bus.ID_UsesRm & (stage_q.rd == bus.ID_RegisterRm2)));

  // A flush discards the dependent instruction and HOLD freezes the front
  // end anyway, so neither should also stall fetch.
  assign bus.STALL = load_use & ~bus.FLUSH & ~bus.HOLD;

  // Priority: flush, hold, load-use bubble, idle bubble, normal capture.
  // Only load-use bubbles are counted.
  always_comb begin
    stage_d      = stage_q;
    bubble_cnt_d = bubble_cnt_q;
    if (bus.FLUSH) begin
      stage_d = BUBBLE;
    end else if (!bus.HOLD) begin
      if (load_use) begin
        stage_d = BUBBLE;
        if (bubble_cnt_q != CNT_MAX) begin
          bubble_cnt_d = bubble_cnt_q + CNT_WIDTH'(1);
        end
      end else if (!bus.ID_Valid) begin
        stage_d = BUBBLE;
      end else begin
        stage_d = capture;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      stage_q      <= BUBBLE;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.ID_EX_Valid       = stage_q.valid;
  assign bus.ID_EX_RegisterRn1 = stage_q.rn1;
  assign bus.ID_EX_RegisterRm2 = stage_q.rm2;
  assign bus.ID_EX_UsesRm      = stage_q.uses_rm;
  assign bus.ID_EX_RegisterRd  = stage_q.rd;
  assign bus.ID_EX_RegData1    = stage_q.reg_data1;
  assign bus.ID_EX_RegData2    = stage_q.reg_data2;
  assign bus.ID_EX_SignExtImm  = stage_q.sign_ext_imm;
  assign bus.ID_EX_PC          = stage_q.pc;
  assign bus.ID_EX_RegWrite    = stage_q.reg_write;
  assign bus.ID_EX_MemRead     = stage_q.mem_read;
  assign bus.ID_EX_MemWrite    = stage_q.mem_write;
  assign bus.ID_EX_MemtoReg    = stage_q.mem_to_reg;
  assign bus.ID_EX_ALUSrc      = stage_q.alu_src;
  assign bus.ID_EX_Branch      = stage_q.branch;
  assign bus.ID_EX_ALUOp       = stage_q.alu_op;
  assign bus.BubbleCount       = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage
// Scoreboard bench for id_ex_stage. Directed vectors carry hand-computed
// expectations; applyStimulus drives a vector and queues it, and a separate
// monitor pops each entry, checks STALL before the edge and the registered
// contents after it. A second instance with a 2-bit counter shares the same
// stimulus to exercise counter saturation.
// Control byte layout: {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,Branch,ALUOp}
// ---------------------------------------------------------------------------
module tb_id_ex_stage;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) bus ();
  id_ex_stage_if #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .CNT_WIDTH(2))  bus_n ();

  id_ex_stage #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ZERO_REG(31), .CNT_WIDTH(16)) dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  id_ex_stage #(.DATA_WIDTH(64), .REG_ADDR_WIDTH(5), .ZERO_REG(31), .CNT_WIDTH(2)) dut_n (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .bus     (bus_n)
  );

  // The narrow-counter instance mirrors every input of the main one.
  assign bus_n.HOLD           = bus.HOLD;
  assign bus_n.FLUSH          = bus.FLUSH;
  assign bus_n.ID_Valid       = bus.ID_Valid;
  assign bus_n.ID_RegisterRn1 = bus.ID_RegisterRn1;
  assign bus_n.ID_RegisterRm2 = bus.ID_RegisterRm2;
  assign bus_n.ID_UsesRm      = bus.ID_UsesRm;
  assign bus_n.ID_RegisterRd  = bus.ID_RegisterRd;
  assign bus_n.ID_RegData1    = bus.ID_RegData1;
  assign bus_n.ID_RegData2    = bus.ID_RegData2;
  assign bus_n.ID_SignExtImm  = bus.ID_SignExtImm;
  assign bus_n.ID_PC          = bus.ID_PC;
  assign bus_n.ID_RegWrite    = bus.ID_RegWrite;
  assign bus_n.ID_MemRead     = bus.ID_MemRead;
  assign bus_n.ID_MemWrite    = bus.ID_MemWrite;
  assign bus_n.ID_MemtoReg    = bus.ID_MemtoReg;
  assign bus_n.ID_ALUSrc      = bus.ID_ALUSrc;
  assign bus_n.ID_Branch      = bus.ID_Branch;
  assign bus_n.ID_ALUOp       = bus.ID_ALUOp;

  typedef struct {
    string      name;
    logic       hold;
    logic       flush;
    logic       id_valid;
    logic       uses_rm;
    logic [4:0] rn1;
    logic [4:0] rm2;
    logic [4:0] rd;
    logic [7:0] ctrl;
    int         tag;
    logic       e_stall;
    logic       e_valid;
    logic [4:0] e_rn1;
    logic [4:0] e_rm2;
    logic [4:0] e_rd;
    logic [7:0] e_ctrl;
    int         e_tag;
    int         e_cnt;
    int         e_cntn;
  } vec_t;

  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Data fields are derived from a tag so a stage image can be predicted
  // from one number; tag 0 means an all-zero (bubble) payload.
  function automatic logic [63:0] dataOf(int tag, int which);
    if (tag == 0) return 64'd0;
    case (which)
      0:       return 64'hA000_0000_0000_0000 | 64'(tag);
      1:       return 64'hB000_0000_0000_0000 | 64'(tag);
      2:       return 64'hC000_0000_0000_0000 | 64'(tag);
      default: return 64'h0000_0000_0040_0000 + 64'(tag * 4);
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic checkReset(input string pfx);
    checkOutput({pfx, ".Valid"},   64'(bus.ID_EX_Valid), 64'd0);
    checkOutput({pfx, ".Rn1"},     64'(bus.ID_EX_RegisterRn1), 64'd31);
    checkOutput({pfx, ".Rm2"},     64'(bus.ID_EX_RegisterRm2), 64'd31);
    checkOutput({pfx, ".Rd"},      64'(bus.ID_EX_RegisterRd), 64'd31);
    checkOutput({pfx, ".MemRead"}, 64'(bus.ID_EX_MemRead), 64'd0);
    checkOutput({pfx, ".ALUOp"},   64'(bus.ID_EX_ALUOp), 64'd0);
    checkOutput({pfx, ".RegData1"}, bus.ID_EX_RegData1, 64'd0);
    checkOutput({pfx, ".PC"},      bus.ID_EX_PC, 64'd0);
    checkOutput({pfx, ".STALL"},   64'(bus.STALL), 64'd0);
    checkOutput({pfx, ".BubbleCount"}, 64'(bus.BubbleCount), 64'd0);
    checkOutput({pfx, ".BubbleCountN"}, 64'(bus_n.BubbleCount), 64'd0);
  endtask

  task automatic driveVector(input vec_t v);
    bus.HOLD           = v.hold;
    bus.FLUSH          = v.flush;
    bus.ID_Valid       = v.id_valid;
    bus.ID_UsesRm      = v.uses_rm;
    bus.ID_RegisterRn1 = v.rn1;
    bus.ID_RegisterRm2 = v.rm2;
    bus.ID_RegisterRd  = v.rd;
    bus.ID_RegWrite    = v.ctrl[7];
    bus.ID_MemRead     = v.ctrl[6];
    bus.ID_MemWrite    = v.ctrl[5];
    bus.ID_MemtoReg    = v.ctrl[4];
    bus.ID_ALUSrc      = v.ctrl[3];
    bus.ID_Branch      = v.ctrl[2];
    bus.ID_ALUOp       = v.ctrl[1:0];
    bus.ID_RegData1    = dataOf(v.tag, 0);
    bus.ID_RegData2    = dataOf(v.tag, 1);
    bus.ID_SignExtImm  = dataOf(v.tag, 2);
    bus.ID_PC          = dataOf(v.tag, 3);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveVector(v);
    exp_q.push_back(v);
  endtask

  // Monitor: STALL is checked mid-low-phase, the stage image just after the
  // following rising edge.
  initial begin
    vec_t e;
    logic [7:0] ctrl_got;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput({e.name, ".STALL"}, 64'(bus.STALL), 64'(e.e_stall));
        @(posedge clk);
        #1;
        ctrl_got = {bus.ID_EX_RegWrite, bus.ID_EX_MemRead, bus.ID_EX_MemWrite,
                    bus.ID_EX_MemtoReg, bus.ID_EX_ALUSrc, bus.ID_EX_Branch,
                    bus.ID_EX_ALUOp};
        checkOutput({e.name, ".Valid"},    64'(bus.ID_EX_Valid), 64'(e.e_valid));
        checkOutput({e.name, ".Rn1"},      64'(bus.ID_EX_RegisterRn1), 64'(e.e_rn1));
        checkOutput({e.name, ".Rm2"},      64'(bus.ID_EX_RegisterRm2), 64'(e.e_rm2));
        checkOutput({e.name, ".Rd"},       64'(bus.ID_EX_RegisterRd), 64'(e.e_rd));
        checkOutput({e.name, ".Ctrl"},     64'(ctrl_got), 64'(e.e_ctrl));
        checkOutput({e.name, ".RegData1"}, bus.ID_EX_RegData1, dataOf(e.e_tag, 0));
        checkOutput({e.name, ".RegData2"}, bus.ID_EX_RegData2, dataOf(e.e_tag, 1));
        checkOutput({e.name, ".SignExtImm"}, bus.ID_EX_SignExtImm, dataOf(e.e_tag, 2));
        checkOutput({e.name, ".PC"},       bus.ID_EX_PC, dataOf(e.e_tag, 3));
        checkOutput({e.name, ".BubbleCount"},  64'(bus.BubbleCount), 64'(e.e_cnt));
        checkOutput({e.name, ".BubbleCountN"}, 64'(bus_n.BubbleCount), 64'(e.e_cntn));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t v;
    rst_n = 1'b0;
    v = '{"idle", 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 8'h00, 0,
          1'b0, 1'b0, 5'd31, 5'd31, 5'd31, 8'h00, 0, 0, 0};
    driveVector(v);
    #12;
    checkReset("reset");
    rst_n = 1'b1;

    // name hold flush valid usesRm rn1 rm2 rd ctrl tag | stall valid rn1 rm2 rd ctrl tag cnt cntN
    applyStimulus('{"ldur_x2",         1'b0,1'b0,1'b1,1'b0, 5'd1, 5'd0, 5'd2, 8'hD8, 1,  1'b0,1'b1, 5'd1, 5'd0, 5'd2, 8'hD8, 1, 0,0});
    applyStimulus('{"add_rn_haz",      1'b0,1'b0,1'b1,1'b1, 5'd2, 5'd3, 5'd4, 8'h82, 2,  1'b1,1'b0, 5'd31,5'd31,5'd31,8'h00, 0, 1,1});
    applyStimulus('{"add_rn_capture",  1'b0,1'b0,1'b1,1'b1, 5'd2, 5'd3, 5'd4, 8'h82, 2,  1'b0,1'b1, 5'd2, 5'd3, 5'd4, 8'h82, 2, 1,1});
    applyStimulus('{"ldur_xzr",        1'b0,1'b0,1'b1,1'b0, 5'd4, 5'd0, 5'd31,8'hD8, 3,  1'b0,1'b1, 5'd4, 5'd0, 5'd31,8'hD8, 3, 1,1});
    applyStimulus('{"rn_xzr_nohaz",    1'b0,1'b0,1'b1,1'b1, 5'd31,5'd31,5'd6, 8'h82, 4,  1'b0,1'b1, 5'd31,5'd31,5'd6, 8'h82, 4, 1,1});
    applyStimulus('{"ldur_x5",         1'b0,1'b0,1'b1,1'b0, 5'd1, 5'd0, 5'd5, 8'hD8, 5,  1'b0,1'b1, 5'd1, 5'd0, 5'd5, 8'hD8, 5, 1,1});
    applyStimulus('{"rm_unused_nohaz", 1'b0,1'b0,1'b1,1'b0, 5'd7, 5'd5, 5'd8, 8'h88, 6,  1'b0,1'b1, 5'd7, 5'd5, 5'd8, 8'h88, 6, 1,1});
    applyStimulus('{"ldur_x5_again",   1'b0,1'b0,1'b1,1'b0, 5'd1, 5'd0, 5'd5, 8'hD8, 7,  1'b0,1'b1, 5'd1, 5'd0, 5'd5, 8'hD8, 7, 1,1});
    applyStimulus('{"rm_used_haz",     1'b0,1'b0,1'b1,1'b1, 5'd7, 5'd5, 5'd9, 8'h82, 8,  1'b1,1'b0, 5'd31,5'd31,5'd31,8'h00, 0, 2,2});
    applyStimulus('{"rm_used_capture", 1'b0,1'b0,1'b1,1'b1, 5'd7, 5'd5, 5'd9, 8'h82, 8,  1'b0,1'b1, 5'd7, 5'd5, 5'd9, 8'h82, 8, 2,2});
    applyStimulus('{"ldur_x10",        1'b0,1'b0,1'b1,1'b0, 5'd1, 5'd0, 5'd10,8'hD8, 9,  1'b0,1'b1, 5'd1, 5'd0, 5'd10,8'hD8, 9, 2,2});
    applyStimulus('{"flush_loaduse",   1'b0,1'b1,1'b1,1'b0, 5'd10,5'd0, 5'd11,8'h82, 10, 1'b0,1'b0, 5'd31,5'd31,5'd31,8'h00, 0, 2,2});
    applyStimulus('{"add_after_flush", 1'b0,1'b0,1'b1,1'b0, 5'd10,5'd0, 5'd11,8'h82, 10, 1'b0,1'b1, 5'd10,5'd0, 5'd11,8'h82, 10,2,2});
    applyStimulus('{"hold1",           1'b1,1'b0,1'b1,1'b0, 5'd12,5'd0, 5'd13,8'hD8, 11, 1'b0,1'b1, 5'd10,5'd0, 5'd11,8'h82, 10,2,2});
    applyStimulus('{"hold2",           1'b1,1'b0,1'b1,1'b1, 5'd14,5'd15,5'd16,8'h28, 12, 1'b0,1'b1, 5'd10,5'd0, 5'd11,8'h82, 10,2,2});
    applyStimulus('{"hold3",           1'b1,1'b0,1'b0,1'b0, 5'd20,5'd20,5'd20,8'h82, 13, 1'b0,1'b1, 5'd10,5'd0, 5'd11,8'h82, 10,2,2});
    applyStimulus('{"hold_release",    1'b0,1'b0,1'b1,1'b0, 5'd12,5'd0, 5'd13,8'hD8, 11, 1'b0,1'b1, 5'd12,5'd0, 5'd13,8'hD8, 11,2,2});
    applyStimulus('{"hold_loaduse",    1'b1,1'b0,1'b1,1'b0, 5'd13,5'd0, 5'd14,8'h82, 13, 1'b0,1'b1, 5'd12,5'd0, 5'd13,8'hD8, 11,2,2});
    applyStimulus('{"hold_drop_stall", 1'b0,1'b0,1'b1,1'b0, 5'd13,5'd0, 5'd14,8'h82, 13, 1'b1,1'b0, 5'd31,5'd31,5'd31,8'h00, 0, 3,3});
    applyStimulus('{"add_x13_capture", 1'b0,1'b0,1'b1,1'b0, 5'd13,5'd0, 5'd14,8'h82, 13, 1'b0,1'b1, 5'd13,5'd0, 5'd14,8'h82, 13,3,3});
    applyStimulus('{"id_invalid",      1'b0,1'b0,1'b0,1'b0, 5'd20,5'd0, 5'd21,8'h82, 14, 1'b0,1'b0, 5'd31,5'd31,5'd31,8'h00, 0, 3,3});
    applyStimulus('{"ldur_x17",        1'b0,1'b0,1'b1,1'b0, 5'd1, 5'd0, 5'd17,8'hD8, 15, 1'b0,1'b1, 5'd1, 5'd0, 5'd17,8'hD8, 15,3,3});
    applyStimulus('{"add_x17_haz",     1'b0,1'b0,1'b1,1'b0, 5'd17,5'd0, 5'd18,8'h82, 16, 1'b1,1'b0, 5'd31,5'd31,5'd31,8'h00, 0, 4,3});
    applyStimulus('{"add_x17_capture", 1'b0,1'b0,1'b1,1'b0, 5'd17,5'd0, 5'd18,8'h82, 16, 1'b0,1'b1, 5'd17,5'd0, 5'd18,8'h82, 16,4,3});
    applyStimulus('{"ldur_x19",        1'b0,1'b0,1'b1,1'b0, 5'd1, 5'd0, 5'd19,8'hD8, 17, 1'b0,1'b1, 5'd1, 5'd0, 5'd19,8'hD8, 17,4,3});
    applyStimulus('{"add_rm19_haz",    1'b0,1'b0,1'b1,1'b1, 5'd3, 5'd19,5'd20,8'h82, 18, 1'b1,1'b0, 5'd31,5'd31,5'd31,8'h00, 0, 5,3});
    applyStimulus('{"add_rm19_capture",1'b0,1'b0,1'b1,1'b1, 5'd3, 5'd19,5'd20,8'h82, 18, 1'b0,1'b1, 5'd3, 5'd19,5'd20,8'h82, 18,5,3});
    applyStimulus('{"ldur_x21",        1'b0,1'b0,1'b1,1'b0, 5'd1, 5'd0, 5'd21,8'hD8, 19, 1'b0,1'b1, 5'd1, 5'd0, 5'd21,8'hD8, 19,5,3});

    // Present a dependent ADD, confirm it stalls, then reset mid-cycle.
    @(posedge clk);
    #2;
    v = '{"after_reset", 1'b0,1'b0,1'b1,1'b0, 5'd21,5'd0, 5'd22,8'h82, 20,
          1'b0,1'b1, 5'd21,5'd0, 5'd22,8'h82, 20, 0,0};
    driveVector(v);
    #1;
    checkOutput("pre_reset.STALL", 64'(bus.STALL), 64'd1);
    rst_n = 1'b0;
    #1;
    checkReset("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(v);

    @(posedge clk);
    #3;
    checkOutput("scoreboard.pending", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the five-stage ARMv8 core, sitting directly upstream of the forwarding unit.
- Its registered outputs ID_EX_RegisterRn1, ID_EX_RegisterRm2 and ID_EX_RegisterRd are the source and destination fields the forwarding unit compares against EX/MEM and MEM/WB.
- Also holds load-use hazard detection: it stalls PC and IF/ID, and inserts a bubble into EX.
- Handles flush from branch resolution, global hold, and keeps a saturating bubble counter.

Parameters:
- DATA_WIDTH, 64, width of operand, immediate and PC fields
- REG_ADDR_WIDTH, 5, register index width
- ZERO_REG, 31, index of XZR; never a hazard source
- CNT_WIDTH, 16, bubble counter width

Ports:
- CLOCK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous active-low reset
- HOLD  in  1  freeze whole register (memory wait)
- FLUSH  in  1  squash instruction in ID (taken branch)
- ID_Valid  in  1  ID holds a real instruction
- ID_RegisterRn1  in  REG_ADDR_WIDTH  Rn of ID instruction
- ID_RegisterRm2  in  REG_ADDR_WIDTH  Rm of ID instruction
- ID_UsesRm  in  1  ID instruction reads Rm
- ID_RegisterRd  in  REG_ADDR_WIDTH  destination
- ID_RegData1, ID_RegData2, ID_SignExtImm, ID_PC  in  DATA_WIDTH each  operands, immediate, PC
- ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_Branch  in  1 each  control
- ID_ALUOp  in  2  ALU control class
- ID_EX_* (one per ID_* data, address and control input above, plus ID_EX_Valid)  out  same widths  registered stage contents
- STALL  out  1  combinational; hold PC and IF/ID
- BubbleCount  out  CNT_WIDTH  load-use bubbles inserted, saturating

Behaviour:
- Reset (async, RESET_N=0):
  - all ID_EX_* control bits, ID_EX_Valid, ALUOp and data fields go to 0
  - ID_EX_RegisterRn1, Rm2 and Rd go to ZERO_REG
  - BubbleCount goes to 0
  - STALL=0 while in reset
- Hazard, combinational. LoadUse=1 when all of:
  - ID_EX_Valid & ID_EX_MemRead & ID_Valid
  - ID_EX_RegisterRd != ZERO_REG
  - (ID_EX_RegisterRd==ID_RegisterRn1) | (ID_UsesRm & ID_EX_RegisterRd==ID_RegisterRm2)
- STALL = LoadUse & ~FLUSH & ~HOLD.
- Per rising edge, first matching case wins:
  1. FLUSH=1: load bubble.
  2. HOLD=1: all registers keep their values; BubbleCount unchanged.
  3. LoadUse=1: load bubble; BubbleCount+1.
  4. ID_Valid=0: load bubble.
  5. Otherwise: capture every ID_* input into its ID_EX_* register; ID_EX_Valid=1.
- Bubble contents:
  - ID_EX_Valid and RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch go to 0; ALUOp goes to 0
  - RegisterRn1, Rm2 and Rd go to ZERO_REG, so the forwarding unit never matches a bubble
  - data fields go to 0
- Latency:
  - Normal capture is 1 cycle.
  - A load-use stall lasts exactly 1 cycle: the bubble has MemRead=0, so LoadUse drops the next cycle while IF/ID still presents the same instruction, which is then captured.
- BubbleCount:
  - increments only in case 3
  - saturates at all-ones, no wrap
  - FLUSH and ID_Valid bubbles are not counted
- Simultaneous events:
  - FLUSH with LoadUse: bubble, STALL=0, no count (flushed instruction is discarded, fetch redirects).
  - HOLD with LoadUse: STALL=0; the hazard is re-evaluated after HOLD drops. Contents are unchanged, so the stall follows then.
- Reset mid-stall: async clear wins immediately; the first edge after release behaves as from reset (ID_EX_Valid=0, so no LoadUse).
- Rd=ZERO_REG loads (LDUR XZR) never stall.
- ID_RegisterRm2 is ignored when ID_UsesRm=0.

Test Plan:
- Reset: assert RESET_N=0 mid-cycle -> outputs clear without a clock edge; Rn1, Rm2 and Rd read 31; BubbleCount=0.
- Load-use on Rn: EX holds LDUR X2 (Rd=2, MemRead=1); ID presents ADD with Rn1=2 -> STALL=1 for one cycle; next ID_EX is a bubble (Valid=0, Rd=31); the following edge captures ADD; BubbleCount=1.
- Non-hazards:
  - load Rd=31 with ID Rn1=31 -> STALL=0.
  - load Rd=5 with ID Rm2=5, UsesRm=0 -> STALL=0.
  - UsesRm=1 -> STALL=1.
- FLUSH with LoadUse active -> STALL=0; bubble loaded; BubbleCount unchanged.
- HOLD for 3 cycles with new ID inputs -> ID_EX_* unchanged throughout; normal capture on the release edge.
- CNT_WIDTH=2: force 5 load-use stalls -> BubbleCount reads 1, 2, 3, 3, 3.
